// File: rtl/sample_readout_pkg.sv
// Shared constants and types for the sample buffer readout block.
// Optional decimation is enabled with SAMPLE_READOUT_DECIM_EN.
package sample_readout_pkg;
    localparam int DATA_W     = 14;
    localparam int ADDR_W     = 10;
    localparam int MEM_LAT    = 1;
    localparam int FIFO_DEPTH = 2;
    localparam int DECIM_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/sample_readout_if.sv
// Control, buffer-read and output-stream signals of the readout block.
// The decim field exists only when SAMPLE_READOUT_DECIM_EN is defined.
interface sample_readout_if;
    import sample_readout_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] sample_count;
`ifdef SAMPLE_READOUT_DECIM_EN
    logic [DECIM_W-1:0] decim;
`endif
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  start, sample_count,
`ifdef SAMPLE_READOUT_DECIM_EN
        input  decim,
`endif
        input  mem_rd_data, m_ready,
        output busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, sample_count,
`ifdef SAMPLE_READOUT_DECIM_EN
        output decim,
`endif
        output mem_rd_data, m_ready,
        input  busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/sample_readout_fifo2.sv
// Two-entry output FIFO with fall-through: a push into an empty FIFO
// is visible at the head in the same cycle.
module readout_fifo2
    import sample_readout_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_bypass;
    logic w_push_store;
    logic w_pop_store;

    assign w_bypass     = (r_count == 2'd0);
    // A word that is pushed and popped in the same cycle never lands in storage.
    assign w_push_store = i_push && !(w_bypass && i_pop);
    assign w_pop_store  = i_pop && !w_bypass;

    assign o_data  = w_bypass ? i_data : r_mem[r_rd_ptr];
    assign o_empty = w_bypass && !i_push;
    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_store) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_store)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push_store} - {1'b0, w_pop_store};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_store && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/sample_readout.sv
// Reads sample_count words from the sample buffer and streams them out with last.
// Define SAMPLE_READOUT_DECIM_EN to add a stride (decim) to the read addresses.
module sample_readout
    import sample_readout_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    sample_readout_if.master io_bus
);
    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W:0]   r_rd_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [ADDR_W:0]   w_stride;

    logic              w_accept_start;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_last;
    logic [ADDR_W:0]   w_rd_next;
    logic [2:0]        w_occ;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [1:0]        w_fifo_count;
    logic [DATA_W:0]   w_head;

`ifdef SAMPLE_READOUT_DECIM_EN
    logic [DECIM_W-1:0] r_decim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_decim <= '0;
        else if (w_accept_start) r_decim <= io_bus.decim;
    end

    assign w_stride = (r_decim == '0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(r_decim);
`else
    assign w_stride = (ADDR_W+1)'(1);
`endif

    assign w_accept_start = (r_state == S_IDLE) && io_bus.start;
    assign w_valid        = !w_fifo_empty;
    assign w_pop          = w_valid && io_bus.m_ready;
    assign w_rd_next      = r_rd_addr + w_stride;
    // The last-beat marker travels with the data, so decimated counts need no division.
    assign w_issue_last   = (w_rd_next >= {1'b0, r_cnt});
    assign w_occ          = {1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue        = (r_state == S_RUN) && (r_rd_addr < {1'b0, r_cnt}) &&
                            (w_occ < 3'(FIFO_DEPTH)) && !(w_fifo_full && !w_pop);

    readout_fifo2 #(.W(DATA_W + 1)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_accept_start),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, io_bus.mem_rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign io_bus.busy        = (r_state == S_RUN);
    assign io_bus.done        = (r_state == S_DONE);
    assign io_bus.mem_rd_en   = w_issue;
    assign io_bus.mem_rd_addr = r_rd_addr[ADDR_W-1:0];
    assign io_bus.m_valid     = w_valid;
    assign io_bus.m_data      = w_valid ? w_head[DATA_W-1:0] : '0;
    assign io_bus.m_last      = w_valid && w_head[DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start)
                    w_state_next = (io_bus.sample_count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_pop && w_head[DATA_W]) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else if (w_accept_start) begin
            r_cnt           <= io_bus.sample_count;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_issue) r_rd_addr <= w_rd_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
        end
    end
endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout: buffer model with one-cycle read latency,
// stream monitor on the falling edge, immediate-assertion checks.
module tb_sample_readout;
    import sample_readout_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    sample_readout_if io_bus ();

    sample_readout dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (io_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (io_bus.mem_rd_en) io_bus.mem_rd_data <= mem[io_bus.mem_rd_addr];
    end

    // Monitor state
    logic [DATA_W:0]   beat_q [$];
    int                beat_cyc_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int issued, popped, busy_cyc, done_cnt, done_cyc;
    logic done_busy;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    int   t_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stable_valid", {31'b0, io_bus.m_valid}, 32'd1);
                chk("stable_data", {18'b0, io_bus.m_data}, {18'b0, prev_data});
            end
            if (io_bus.mem_rd_en) begin
                addr_q.push_back(io_bus.mem_rd_addr);
                issued++;
            end
            if (io_bus.m_valid && io_bus.m_ready) begin
                beat_q.push_back({io_bus.m_last, io_bus.m_data});
                beat_cyc_q.push_back(cyc);
                popped++;
            end
            if (io_bus.mem_rd_en)
                chk("outstanding_le2", {31'b0, (issued - popped) <= 2}, 32'd1);
            if (io_bus.busy) busy_cyc++;
            if (io_bus.done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = io_bus.busy;
            end
            prev_stall = io_bus.m_valid && !io_bus.m_ready;
            prev_data  = io_bus.m_data;
        end
    end

    task automatic clear_mon();
        beat_q.delete();
        beat_cyc_q.delete();
        addr_q.delete();
        issued = 0; popped = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1;
        done_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int cnt, input int dec);
        io_bus.start        = 1'b1;
        io_bus.sample_count = ADDR_W'(cnt);
`ifdef SAMPLE_READOUT_DECIM_EN
        io_bus.decim        = DECIM_W'(dec);
`else
        if (dec != 0) $display("note: decim %0d ignored in this build", dec);
`endif
        t_start = cyc;
        tick();
        io_bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            if (rand_ready) io_bus.m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        io_bus.m_ready = 1'b1;
        chk("done_seen", {31'b0, done_cnt != 0}, 32'd1);
        tick();
        tick();
    endtask

    task automatic chk_beats(input string tag, input int n, input int first, input int step);
        chk({tag, "_nbeats"}, beat_q.size(), n);
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            logic [DATA_W:0] exp;
            exp = {(i == n - 1), DATA_W'(14'h100 + first + i * step)};
            chk($sformatf("%s_beat%0d", tag, i), {17'b0, beat_q[i]}, {17'b0, exp});
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(14'h100 + i);
        io_bus.start        = 1'b0;
        io_bus.sample_count = '0;
        io_bus.m_ready      = 1'b1;
`ifdef SAMPLE_READOUT_DECIM_EN
        io_bus.decim        = '0;
`endif
        clear_mon();
        tick(); tick();
        chk("rst_valid", {31'b0, io_bus.m_valid}, 32'd0);
        chk("rst_busy", {31'b0, io_bus.busy}, 32'd0);
        chk("rst_done", {31'b0, io_bus.done}, 32'd0);
        chk("rst_rd_en", {31'b0, io_bus.mem_rd_en}, 32'd0);
        rst = 1'b0;
        tick();

        // 8 beats, ready high
        clear_mon();
        pulse_start(8, 0);
        wait_done(40, 1'b0);
        chk_beats("t1", 8, 0, 1);
        chk("t1_first_cyc", beat_cyc_q.size() > 0 ? beat_cyc_q[0] : -1, t_start + 2);
        chk("t1_last_cyc", beat_cyc_q.size() > 0 ? beat_cyc_q[$] : -1, t_start + 9);
        chk("t1_done_cyc", done_cyc, t_start + 10);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_busy", {31'b0, done_busy}, 32'd0);
        chk("t1_busy_cyc", busy_cyc, 9);
        chk("t1_naddr", addr_q.size(), 8);
        for (int i = 0; i < addr_q.size(); i++)
            chk($sformatf("t1_addr%0d", i), {22'b0, addr_q[i]}, i);
        $display("t1 count=8 beats=%0d done_cyc=%0d", beat_q.size(), done_cyc - t_start);

        // zero count
        clear_mon();
        pulse_start(0, 0);
        wait_done(10, 1'b0);
        chk("t2_done_cyc", done_cyc, t_start + 1);
        chk("t2_reads", issued, 0);
        chk("t2_beats", beat_q.size(), 0);
        chk("t2_busy_cyc", busy_cyc, 0);
        $display("t2 count=0 done_cyc=%0d", done_cyc - t_start);

        // 16 beats, random ready
        clear_mon();
        pulse_start(16, 0);
        io_bus.m_ready = 1'b0;
        wait_done(400, 1'b1);
        chk_beats("t3", 16, 0, 1);
        chk("t3_done_cnt", done_cnt, 1);
        $display("t3 count=16 random ready beats=%0d", beat_q.size());

        // restart attempt mid-readout is ignored
        clear_mon();
        pulse_start(16, 0);
        repeat (5) tick();
        pulse_start(3, 0);
        wait_done(60, 1'b0);
        chk_beats("t4", 16, 0, 1);
        chk("t4_done_cnt", done_cnt, 1);
        $display("t4 restart ignored beats=%0d", beat_q.size());

        // reset after 5 of 10 beats
        clear_mon();
        pulse_start(10, 0);
        for (int n = 0; n < 40 && beat_q.size() < 5; n++) tick();
        chk("t5_pre_beats", beat_q.size(), 5);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'b0, io_bus.m_valid}, 32'd0);
        chk("t5_rst_busy", {31'b0, io_bus.busy}, 32'd0);
        chk("t5_rst_rd_en", {31'b0, io_bus.mem_rd_en}, 32'd0);
        chk("t5_rst_last", {31'b0, io_bus.m_last}, 32'd0);
        chk("t5_rst_data", {18'b0, io_bus.m_data}, 32'd0);
        tick();
        rst = 1'b0;
        clear_mon();
        repeat (4) tick();
        chk("t5_no_done", done_cnt, 0);
        pulse_start(4, 0);
        wait_done(30, 1'b0);
        chk_beats("t5", 4, 0, 1);
        $display("t5 reset mid-readout then count=4 beats=%0d", beat_q.size());

`ifdef SAMPLE_READOUT_DECIM_EN
        // decimated readout
        clear_mon();
        pulse_start(10, 3);
        wait_done(40, 1'b0);
        chk_beats("t6", 4, 0, 3);
        chk("t6_naddr", addr_q.size(), 4);
        for (int i = 0; i < addr_q.size(); i++)
            chk($sformatf("t6_addr%0d", i), {22'b0, addr_q[i]}, i * 3);
        $display("t6 decim=3 count=10 beats=%0d", beat_q.size());
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sample_readout.md
Name: sample_readout

Overview:
- Drains a sample buffer that the acquisition sampler has filled.
- On a start pulse, reads `sample_count` 14-bit samples from the buffer memory's synchronous read port, starting at address 0.
- Streams the samples out on a valid/ready interface to the host/transport side, with `last` on the final beat.
- This is the reader end of the sampler's write-into-buffer path.

Parameters:
- DATA_W, 14, sample width in bits.
- ADDR_W, 10, buffer address width; the maximum readable count is 2^ADDR_W-1.
- MEM_LAT, 1, buffer read latency in cycles (fixed 1; other values unsupported).

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin readout
- sample_count  in  ADDR_W  number of samples to read; sampled on the accepted start
- busy  out  1  high from the accepted start until the final beat is accepted
- done  out  1  one-cycle pulse after the final beat is accepted, or after a zero-count start
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_W  buffer read address
- mem_rd_data  in  DATA_W  buffer read data, valid MEM_LAT cycles after mem_rd_en
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  stream sample
- m_last  out  1  marks the final beat of the readout

Behaviour:
- Reset (asynchronous, active-high): state IDLE, all outputs 0, FIFO emptied, any in-flight read discarded.
  - Reset mid-readout aborts the readout with no done pulse.
- States:
  - IDLE: start=1 latches sample_count into cnt_r and clears rd_addr, out_cnt and the FIFO.
    - cnt_r=0 → DONE.
    - Otherwise → RUN; busy=1 from the next cycle.
  - RUN: issue reads and stream out beats (rules below).
    - Leave RUN when the beat with out_cnt=cnt_r-1 is accepted (m_valid & m_ready) → DONE.
  - DONE: done=1, busy=0 for exactly one cycle → IDLE.
- start in RUN or DONE is ignored; sample_count is not re-sampled.
- Read issue:
  - Internal 2-entry output FIFO, plus one in-flight flag.
  - mem_rd_en=1 when in RUN, rd_addr<cnt_r, and (FIFO occupancy + in-flight) < 2, counted after this cycle's pop.
  - mem_rd_addr=rd_addr; rd_addr increments on each issue.
  - The returning mem_rd_data is pushed into the FIFO one cycle after issue.
- Stream:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_last = m_valid & (out_cnt==cnt_r-1).
  - Pop on m_valid & m_ready; out_cnt increments on each pop.
  - Once asserted, m_valid and m_data hold stable until accepted.
- Throughput:
  - With m_ready held high, one beat per cycle after a 2-cycle initial latency.
  - start at cycle t → first read at t+1, first m_valid at t+2.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Addresses never exceed cnt_r-1; there is no wrap-around.
- With m_ready held low, at most 2 reads are outstanding; the read side stalls with no data loss.

Optional Feature:
- Macro SAMPLE_READOUT_DECIM_EN.
- Defined:
  - Adds input decim, 4 bits, sampled on start with sample_count.
  - Read addresses are 0, D, 2D, … with D=decim (0 treated as 1).
  - The number of beats is ceil(cnt_r/D); addresses are always < cnt_r.
  - m_last is on the final decimated beat.
- Undefined: the port is absent and the stride is 1.

Decomposition:
- Package sample_readout_pkg holds:
  - DATA_W and ADDR_W constants;
  - the state enum (IDLE, RUN, DONE);
  - the FIFO depth constant (2).
- One sub-module: readout_fifo2, the 2-entry synchronous FIFO with push/pop/full/empty/count outputs.
- The top level holds the FSM, address/count logic and read issue.

Test Plan:
- Buffer preloaded with mem[i]=i+0x100; start with sample_count=8, m_ready=1 → 8 beats 0x100…0x107 on consecutive cycles; first m_valid 2 cycles after start; m_last only on 0x107; done pulses 1 cycle after the last beat; busy spans the readout.
- sample_count=0 → no mem_rd_en, no m_valid; done pulses the cycle after start; busy stays 0.
- sample_count=16, m_ready random (50%) → all 16 values in order, no duplicates or drops; m_data is stable while m_valid & !m_ready; never more than 2 reads outstanding.
- start pulsed again mid-readout with sample_count=3 → ignored; the original 16-beat readout completes unchanged.
- Reset asserted after 5 of 10 beats → outputs 0 immediately; no done pulse; a new start with count 4 yields beats 0x100…0x103.
- With DECIM_EN, sample_count=10, decim=3 → addresses 0,3,6,9; 4 beats; m_last on mem[9].
